key_debounce: RTL and testbench

Multi-key input conditioner between the board push-buttons and the button edge detector. Each raw button pin is synchronised to `sys_clk` and normalised to active-high. The block then passes it through a per-key debounce state machine and drives a clean, stable level. The edge detector consumes `o_key[n]` as its button input and turns it into one-cycle press/release flags.

---
 rtl/key_debounce.sv | 110 +++++++++++
 tb/tb_key_debounce.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// Multi-key push-button conditioner: two-flop synchroniser, polarity normalisation
// and an independent four-state debounce FSM per key driving a clean active-high level.
module key_debounce #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic [NUM_KEYS-1:0] i_key_raw,
    output logic [NUM_KEYS-1:0] o_key,
    output logic [NUM_KEYS-1:0] o_key_busy
);

    typedef enum logic [1:0] {
        S_LOW  = 2'b00,
        S_RISE = 2'b01,
        S_HIGH = 2'b10,
        S_FALL = 2'b11
    } state_e;

    localparam logic [NUM_KEYS-1:0] IDLE_LVL = {NUM_KEYS{ACTIVE_LOW}};
    localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]    CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_KEYS-1:0] sync1_q;
    logic [NUM_KEYS-1:0] sync2_q;
    logic [NUM_KEYS-1:0] key_s;

    // Synchroniser resets to the released pin level so reset never looks like a press.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            sync1_q <= IDLE_LVL;
            sync2_q <= IDLE_LVL;
        end else begin
            sync1_q <= i_key_raw;
            sync2_q <= sync1_q;
        end
    end

    assign key_s = sync2_q ^ IDLE_LVL;

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        state_e           state_q;
        state_e           state_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;

        always_ff @(posedge sys_clk or posedge sys_rst) begin
            if (sys_rst) begin
                state_q <= S_LOW;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        // cnt counts consecutive samples at the candidate level, including the one that entered the state.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
                S_LOW: begin
                    if (key_s[k]) begin
                        state_d = S_RISE;
                        cnt_d   = CNT_ONE;
                    end
                end
                S_RISE: begin
                    if (!key_s[k]) begin
                        state_d = S_LOW;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d = S_HIGH;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                S_HIGH: begin
                    if (!key_s[k]) begin
                        state_d = S_FALL;
                        cnt_d   = CNT_ONE;
                    end
                end
                S_FALL: begin
                    if (key_s[k]) begin
                        state_d = S_HIGH;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_MAX) begin
                        state_d = S_LOW;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = S_LOW;
                    cnt_d   = '0;
                end
            endcase
        end

        assign o_key[k]      = (state_q == S_HIGH) || (state_q == S_FALL);
        assign o_key_busy[k] = (state_q == S_RISE) || (state_q == S_FALL);
    end

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce: 2 keys, 4-cycle debounce, active-low pins.
module tb_key_debounce;

    logic       sys_clk;
    logic       sys_rst;
    logic [1:0] i_key_raw;
    logic [1:0] o_key;
    logic [1:0] o_key_busy;

    int n_checks = 0;
    int n_errors = 0;

    key_debounce #(
        .NUM_KEYS       (2),
        .DEBOUNCE_CYCLES(4),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .i_key_raw (i_key_raw),
        .o_key     (o_key),
        .o_key_busy(o_key_busy)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    task automatic check_eq(input string tag, input logic [1:0] got, input logic [1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b, expected %b", tag, got, exp);
        end
    endtask

    // Apply raw pins, take one clock edge, then check both outputs 1 ns after it.
    task automatic drive_step(input logic [1:0] raw, input logic [1:0] exp_key,
                              input logic [1:0] exp_busy, input string tag);
        i_key_raw = raw;
        @(posedge sys_clk);
        #1;
        check_eq({tag, "/key"}, o_key, exp_key);
        check_eq({tag, "/busy"}, o_key_busy, exp_busy);
    endtask

    initial begin
        sys_rst   = 1'b1;
        i_key_raw = 2'b11;

        // 1: reset held, then released with keys idle
        repeat (5) drive_step(2'b11, 2'b00, 2'b00, "t1 rst");
        sys_rst = 1'b0;
        repeat (10) drive_step(2'b11, 2'b00, 2'b00, "t1 idle");

        // 2: clean press of key 0 for 20 cycles, then release
        drive_step(2'b10, 2'b00, 2'b00, "t2 e0");
        drive_step(2'b10, 2'b00, 2'b00, "t2 e1");
        drive_step(2'b10, 2'b00, 2'b01, "t2 e2");
        drive_step(2'b10, 2'b00, 2'b01, "t2 e3");
        drive_step(2'b10, 2'b00, 2'b01, "t2 e4");
        drive_step(2'b10, 2'b01, 2'b00, "t2 e5");
        repeat (14) drive_step(2'b10, 2'b01, 2'b00, "t2 hold");
        drive_step(2'b11, 2'b01, 2'b00, "t2 rel e0");
        drive_step(2'b11, 2'b01, 2'b00, "t2 rel e1");
        drive_step(2'b11, 2'b01, 2'b01, "t2 rel e2");
        drive_step(2'b11, 2'b01, 2'b01, "t2 rel e3");
        drive_step(2'b11, 2'b01, 2'b01, "t2 rel e4");
        drive_step(2'b11, 2'b00, 2'b00, "t2 rel e5");
        repeat (4) drive_step(2'b11, 2'b00, 2'b00, "t2 idle");

        // 3a: 3-cycle low pulse is rejected
        drive_step(2'b10, 2'b00, 2'b00, "t3a e0");
        drive_step(2'b10, 2'b00, 2'b00, "t3a e1");
        drive_step(2'b10, 2'b00, 2'b01, "t3a e2");
        drive_step(2'b11, 2'b00, 2'b01, "t3a e3");
        drive_step(2'b11, 2'b00, 2'b01, "t3a e4");
        drive_step(2'b11, 2'b00, 2'b00, "t3a e5");
        repeat (7) drive_step(2'b11, 2'b00, 2'b00, "t3a gap");

        // 3b: 4-cycle low pulse is accepted, then released
        drive_step(2'b10, 2'b00, 2'b00, "t3b e0");
        drive_step(2'b10, 2'b00, 2'b00, "t3b e1");
        drive_step(2'b10, 2'b00, 2'b01, "t3b e2");
        drive_step(2'b10, 2'b00, 2'b01, "t3b e3");
        drive_step(2'b11, 2'b00, 2'b01, "t3b e4");
        drive_step(2'b11, 2'b01, 2'b00, "t3b e5");
        drive_step(2'b11, 2'b01, 2'b01, "t3b e6");
        drive_step(2'b11, 2'b01, 2'b01, "t3b e7");
        drive_step(2'b11, 2'b01, 2'b01, "t3b e8");
        drive_step(2'b11, 2'b00, 2'b00, "t3b e9");
        repeat (3) drive_step(2'b11, 2'b00, 2'b00, "t3b idle");

        // 4: bounce low2 high1 low3 high2 then low held
        drive_step(2'b10, 2'b00, 2'b00, "t4 e0");
        drive_step(2'b10, 2'b00, 2'b00, "t4 e1");
        drive_step(2'b11, 2'b00, 2'b01, "t4 e2");
        drive_step(2'b10, 2'b00, 2'b01, "t4 e3");
        drive_step(2'b10, 2'b00, 2'b00, "t4 e4");
        drive_step(2'b10, 2'b00, 2'b01, "t4 e5");
        drive_step(2'b11, 2'b00, 2'b01, "t4 e6");
        drive_step(2'b11, 2'b00, 2'b01, "t4 e7");
        drive_step(2'b10, 2'b00, 2'b00, "t4 e8");
        drive_step(2'b10, 2'b00, 2'b00, "t4 e9");
        drive_step(2'b10, 2'b00, 2'b01, "t4 e10");
        drive_step(2'b10, 2'b00, 2'b01, "t4 e11");
        drive_step(2'b10, 2'b00, 2'b01, "t4 e12");
        drive_step(2'b10, 2'b01, 2'b00, "t4 e13");
        drive_step(2'b11, 2'b01, 2'b00, "t4 rel e0");
        drive_step(2'b11, 2'b01, 2'b00, "t4 rel e1");
        drive_step(2'b11, 2'b01, 2'b01, "t4 rel e2");
        drive_step(2'b11, 2'b01, 2'b01, "t4 rel e3");
        drive_step(2'b11, 2'b01, 2'b01, "t4 rel e4");
        drive_step(2'b11, 2'b00, 2'b00, "t4 rel e5");
        repeat (3) drive_step(2'b11, 2'b00, 2'b00, "t4 idle");

        // 5: both keys pressed together, key 1 bounces low2 high1 low held
        drive_step(2'b00, 2'b00, 2'b00, "t5 e0");
        drive_step(2'b00, 2'b00, 2'b00, "t5 e1");
        drive_step(2'b10, 2'b00, 2'b11, "t5 e2");
        drive_step(2'b00, 2'b00, 2'b11, "t5 e3");
        drive_step(2'b00, 2'b00, 2'b01, "t5 e4");
        drive_step(2'b00, 2'b01, 2'b10, "t5 e5");
        drive_step(2'b00, 2'b01, 2'b10, "t5 e6");
        drive_step(2'b00, 2'b01, 2'b10, "t5 e7");
        drive_step(2'b00, 2'b11, 2'b00, "t5 e8");
        drive_step(2'b11, 2'b11, 2'b00, "t5 rel e0");
        drive_step(2'b11, 2'b11, 2'b00, "t5 rel e1");
        drive_step(2'b11, 2'b11, 2'b11, "t5 rel e2");
        drive_step(2'b11, 2'b11, 2'b11, "t5 rel e3");
        drive_step(2'b11, 2'b11, 2'b11, "t5 rel e4");
        drive_step(2'b11, 2'b00, 2'b00, "t5 rel e5");
        repeat (3) drive_step(2'b11, 2'b00, 2'b00, "t5 idle");

        // 6: async reset mid-qualification with key 0 held through it
        drive_step(2'b10, 2'b00, 2'b00, "t6 e0");
        drive_step(2'b10, 2'b00, 2'b00, "t6 e1");
        drive_step(2'b10, 2'b00, 2'b01, "t6 e2");
        drive_step(2'b10, 2'b00, 2'b01, "t6 e3");
        #3;
        sys_rst = 1'b1;
        #1;
        check_eq("t6 async/key", o_key, 2'b00);
        check_eq("t6 async/busy", o_key_busy, 2'b00);
        repeat (2) drive_step(2'b10, 2'b00, 2'b00, "t6 rst");
        sys_rst = 1'b0;
        drive_step(2'b10, 2'b00, 2'b00, "t6 post e0");
        drive_step(2'b10, 2'b00, 2'b00, "t6 post e1");
        drive_step(2'b10, 2'b00, 2'b01, "t6 post e2");
        drive_step(2'b10, 2'b00, 2'b01, "t6 post e3");
        drive_step(2'b10, 2'b00, 2'b01, "t6 post e4");
        drive_step(2'b10, 2'b01, 2'b00, "t6 post e5");
        drive_step(2'b10, 2'b01, 2'b00, "t6 post hold");

        // async reset while the debounced level is high
        #3;
        sys_rst = 1'b1;
        #1;
        check_eq("t6 async hi/key", o_key, 2'b00);
        check_eq("t6 async hi/busy", o_key_busy, 2'b00);
        repeat (2) drive_step(2'b11, 2'b00, 2'b00, "t6 rst2");
        sys_rst = 1'b0;
        repeat (5) drive_step(2'b11, 2'b00, 2'b00, "t6 idle");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
